// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin front end that shares one pipelined barrel shifter among NREQ clients.
// Latency: result strobes LAT+1 clocks after the accepting edge; one operation issued per clock.
// Backpressure: req_ready grants at most one valid client per cycle; responses cannot be stalled.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-client handshake; req_ready is one-hot or zero
//   req_shift/req_data    per-client operands, client i at [i*WSH +: WSH] / [i*W +: W]
//   sh_shift/sh_din       registered operands driven into the shared shifter
//   sh_dout               shifter result, valid LAT clocks after sh_shift/sh_din
//   rsp_valid/rsp_id      one-hot result strobe and owner index for rsp_data
//   rsp_data              registered shift result
//   inflight              operations accepted but not yet returned (0..LAT+1)

module shift_arbiter #(
  parameter int W    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int WSH = $clog2(W),
  localparam int WID = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*WSH-1:0] req_shift,
  input  logic [NREQ*W-1:0]   req_data,
  output logic [WSH-1:0]      sh_shift,
  output logic [W-1:0]        sh_din,
  input  logic [W-1:0]        sh_dout,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [WID-1:0]      rsp_id,
  output logic [W-1:0]        rsp_data,
  output logic [WID+1:0]      inflight
);

  localparam logic [WID+1:0] INF_ONE = {{(WID+1){1'b0}}, 1'b1};

  // (base + off) mod NREQ; NREQ need not be a power of two, so the wrap is explicit.
  function automatic logic [WID-1:0] wrap_add(input logic [WID-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return WID'(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [WID-1:0] ptr;      // highest-priority client this cycle
  logic [WID-1:0] gnt_id;   // granted client (0 when nobody is valid)
  logic           gnt_any;  // a grant is issued, i.e. an accept happens at this edge

  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    // Scan ptr, ptr+1, ... and take the first valid client.
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[wrap_add(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_id  = wrap_add(ptr, k);
      end
    end
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  // Operand select for the granted client.
  logic [W-1:0]   sel_data;
  logic [WSH-1:0] sel_shift;

  always_comb begin
    sel_data  = req_data[gnt_id*W +: W];
    sel_shift = req_shift[gnt_id*WSH +: WSH];
  end

  // ---------------------------------------------------------------------------
  // Issue stage: operand registers into the shifter and pointer rotation.
  // Operands hold when nothing is accepted so the shifter input stays quiet.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      sh_shift <= '0;
      sh_din   <= '0;
    end else if (gnt_any) begin
      ptr      <= wrap_add(gnt_id, 1);
      sh_shift <= sel_shift;
      sh_din   <= sel_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: stage 0 is loaded alongside sh_din/sh_shift, then LAT more
  // stages follow so that stage LAT lines up with the cycle sh_dout is valid.
  // Only the valid bits need clearing on reset; stale ids are never used.
  // ---------------------------------------------------------------------------
  logic [LAT:0]          tag_vld;
  logic [LAT:0][WID-1:0] tag_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= gnt_any;
      tag_id[0]  <= gnt_id;
      for (int i = 1; i <= LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // A response is launched on the edge where the last tag stage is valid.
  logic rsp_fire;
  assign rsp_fire = tag_vld[LAT];

  // ---------------------------------------------------------------------------
  // Response stage: capture the shifter output with its owner.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_data  <= sh_dout;
      rsp_id    <= tag_id[LAT];
      rsp_valid <= rsp_fire ? (NREQ'(1) << tag_id[LAT]) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight counter. The decrement is taken on the same edge that raises
  // rsp_valid, so a full pipeline (issue every clock) settles at LAT+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({gnt_any, rsp_fire})
        2'b10:   inflight <= inflight + INF_ONE;
        2'b01:   inflight <= inflight - INF_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
